// File: rtl/sdram_frame_prefetch.sv
// rtl/sdram_frame_prefetch.sv - frame prefetcher: SDRAM bridge read master feeding a FWFT FIFO
// One outstanding single-word read at a time; a request is only raised when the FIFO has room for its reply.
module sdram_frame_prefetch #(
   parameter int FIFO_DEPTH  = 16,
   parameter int FRAME_WORDS = 76800,
   parameter int ADDR_W      = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              stop_i,
   input  logic [ADDR_W-1:0] base_addr_i,
   output logic              mem_stb_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic              mem_cyc_i,
   input  logic [15:0]       mem_dat_i,
   input  logic              pix_rd_i,
   output logic [15:0]       pix_data_o,
   output logic              pix_valid_o,
   output logic              frame_done_o,
   output logic              underflow_o,
   output logic              active_o
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FRAME_WORDS);

   typedef enum logic [2:0] {IDLE, REQ, WAIT_ACC, WAIT_DATA, PUSH} state_t;

   state_t            state;
   logic [ADDR_W-1:0] base;
   logic [CNT_W-1:0]  word_cnt;
   logic [15:0]       captured;
   logic              start_pend;
   logic              stop_pend;
   logic              stb;
   logic              done;
   logic              underflow;

   logic [15:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W:0]    count;
   logic              push;
   logic              pop;
   logic              flush;
   logic              restart;
   logic              last_word;

   assign restart   = start_i || start_pend;
   assign last_word = (word_cnt == CNT_W'(FRAME_WORDS - 1));

   // A restart requested mid-transaction flushes at PUSH, which also drops the in-flight word.
   always_comb begin
      flush = 1'b0;
      push  = 1'b0;
      case (state)
         IDLE, REQ: flush = start_i;
         PUSH: begin
            flush = restart;
            push  = !restart;
         end
         default: ;
      endcase
   end

   assign pop = pix_rd_i && pix_valid_o && !flush;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + (PTR_W + 1)'(1);
            2'b01:   count <= count - (PTR_W + 1)'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr] <= captured;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         underflow <= 1'b0;
      end else if (start_i) begin
         underflow <= 1'b0;
      end else if (pix_rd_i && !pix_valid_o) begin
         underflow <= 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state      <= IDLE;
         stb        <= 1'b0;
         done       <= 1'b0;
         base       <= '0;
         word_cnt   <= '0;
         captured   <= '0;
         start_pend <= 1'b0;
         stop_pend  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, REQ: begin
               if (start_i) begin
                  base     <= base_addr_i;
                  word_cnt <= '0;
                  state    <= REQ;
               end else if (state == REQ) begin
                  if (stop_i) begin
                     state <= IDLE;
                  end else if (count < (PTR_W + 1)'(FIFO_DEPTH)) begin
                     stb   <= 1'b1;
                     state <= WAIT_ACC;
                  end
               end
            end
            WAIT_ACC, WAIT_DATA: begin
               if (start_i) begin
                  start_pend <= 1'b1;
                  stop_pend  <= 1'b0;
               end else if (stop_i && !start_pend) begin
                  stop_pend <= 1'b1;
               end
               if (state == WAIT_ACC) begin
                  if (mem_cyc_i) begin
                     stb   <= 1'b0;
                     state <= WAIT_DATA;
                  end
               end else if (!mem_cyc_i) begin
                  captured <= mem_dat_i;
                  state    <= PUSH;
               end
            end
            PUSH: begin
               start_pend <= 1'b0;
               stop_pend  <= 1'b0;
               if (restart) begin
                  base     <= base_addr_i;
                  word_cnt <= '0;
                  state    <= REQ;
               end else begin
                  if (last_word) begin
                     word_cnt <= '0;
                     base     <= base_addr_i;
                     done     <= 1'b1;
                  end else begin
                     word_cnt <= word_cnt + CNT_W'(1);
                  end
                  state <= (stop_pend || stop_i) ? IDLE : REQ;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign mem_stb_o    = stb;
   assign mem_we_o     = 1'b1;
   assign mem_addr_o   = base + ADDR_W'(word_cnt);
   assign pix_valid_o  = (count != '0);
   assign pix_data_o   = pix_valid_o ? mem[rd_ptr] : 16'h0000;
   assign frame_done_o = done;
   assign underflow_o  = underflow;
   assign active_o     = (state != IDLE);
endmodule

// File: tb/tb_sdram_frame_prefetch.sv
// tb/tb_sdram_frame_prefetch.sv - randomized bench for sdram_frame_prefetch with bridge model and word scoreboard
module tb_sdram_frame_prefetch;
   localparam int FIFO_DEPTH  = 4;
   localparam int FRAME_WORDS = 8;
   localparam int ADDR_W      = 32;

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic              start_i;
   logic              stop_i;
   logic [ADDR_W-1:0] base_addr_i;
   logic              mem_stb_o;
   logic              mem_we_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic              mem_cyc_i;
   logic [15:0]       mem_dat_i;
   logic              pix_rd_i;
   logic [15:0]       pix_data_o;
   logic              pix_valid_o;
   logic              frame_done_o;
   logic              underflow_o;
   logic              active_o;

   sdram_frame_prefetch #(
      .FIFO_DEPTH(FIFO_DEPTH),
      .FRAME_WORDS(FRAME_WORDS),
      .ADDR_W(ADDR_W)
   ) dut (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .start_i(start_i),
      .stop_i(stop_i),
      .base_addr_i(base_addr_i),
      .mem_stb_o(mem_stb_o),
      .mem_we_o(mem_we_o),
      .mem_addr_o(mem_addr_o),
      .mem_cyc_i(mem_cyc_i),
      .mem_dat_i(mem_dat_i),
      .pix_rd_i(pix_rd_i),
      .pix_data_o(pix_data_o),
      .pix_valid_o(pix_valid_o),
      .frame_done_o(frame_done_o),
      .underflow_o(underflow_o),
      .active_o(active_o)
   );

   always #5 clk_i = ~clk_i;

   int vectors = 0;
   int errors  = 0;

   // Reference model: expected request stream (base + index mod frame) and the ordered word stream.
   logic [ADDR_W-1:0] m_base = '0;
   int                m_idx = 0;
   logic [15:0]       out_q[$];
   int                exp_done = 0;
   int                done_cnt = 0;
   int                req_cnt = 0;
   int                req_target = 0;
   bit                bridge_en = 1'b1;
   bit                discard = 1'b0;
   bit                busy = 1'b0;
   bit                saw_invalid = 1'b0;
   int                acc_max = 2;
   int                lat_min = 1;
   int                lat_span = 3;
   int                pop_mode = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   function automatic bit cond(input int sel);
      case (sel)
         0:       return !active_o;
         1:       return mem_stb_o;
         2:       return mem_cyc_i && !mem_stb_o;
         3:       return !pix_valid_o;
         4:       return req_cnt >= req_target;
         5:       return !busy;
         default: return 1'b0;
      endcase
   endfunction

   task automatic wait_until(input string tag, input int sel, input int limit);
      int n = 0;
      while (!cond(sel) && n < limit) begin
         tick();
         n++;
      end
      check_eq({tag, "_reached"}, 32'(cond(sel)), 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_stb"}, 32'(mem_stb_o), 32'd0);
      check_eq({tag, "_we"}, 32'(mem_we_o), 32'd1);
      check_eq({tag, "_addr"}, mem_addr_o, 32'd0);
      check_eq({tag, "_valid"}, 32'(pix_valid_o), 32'd0);
      check_eq({tag, "_data"}, 32'(pix_data_o), 32'd0);
      check_eq({tag, "_done"}, 32'(frame_done_o), 32'd0);
      check_eq({tag, "_underflow"}, 32'(underflow_o), 32'd0);
      check_eq({tag, "_active"}, 32'(active_o), 32'd0);
   endtask

   task automatic start_idle(input logic [ADDR_W-1:0] base);
      base_addr_i = base;
      m_base      = base;
      m_idx       = 0;
      out_q.delete();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      check_eq("start_clears_underflow", 32'(underflow_o), 32'd0);
   endtask

   task automatic stop_and_drain(input string tag);
      stop_i = 1'b1;
      tick();
      stop_i = 1'b0;
      wait_until({tag, "_idle"}, 0, 300);
      pop_mode = 2;
      wait_until({tag, "_drain"}, 3, 50);
      pop_mode = 0;
      tick();
      tick();
      check_eq({tag, "_words_left"}, 32'(out_q.size()), 32'd0);
      check_eq({tag, "_stb_idle"}, 32'(mem_stb_o), 32'd0);
      check_eq({tag, "_active"}, 32'(active_o), 32'd0);
   endtask

   // Bridge model: accepts a strobe, answers with addr[15:0] after random accept/data latency.
   initial begin
      logic [ADDR_W-1:0] a;
      int                idx;
      mem_cyc_i = 1'b0;
      mem_dat_i = 16'h0000;
      forever begin
         @(negedge clk_i);
         if (!rst_i && bridge_en && mem_stb_o && !mem_cyc_i) begin
            a = mem_addr_o;
            check_eq("req_addr", a, m_base + ADDR_W'(m_idx));
            idx   = m_idx;
            m_idx = (m_idx + 1) % FRAME_WORDS;
            req_cnt++;
            busy = 1'b1;
            repeat ($urandom_range(acc_max, 0)) @(negedge clk_i);
            mem_cyc_i = 1'b1;
            repeat (lat_min + int'($urandom_range(lat_span, 0))) @(negedge clk_i);
            mem_cyc_i = 1'b0;
            mem_dat_i = a[15:0];
            if (discard) begin
               discard = 1'b0;
            end else begin
               out_q.push_back(a[15:0]);
               if (idx == FRAME_WORDS - 1) exp_done++;
            end
            busy = 1'b0;
         end
      end
   end

   initial begin
      pix_rd_i = 1'b0;
      forever begin
         @(posedge clk_i);
         #2;
         case (pop_mode)
            0:       pix_rd_i = 1'b0;
            1:       pix_rd_i = 1'($urandom_range(1, 0));
            2:       pix_rd_i = 1'b1;
            default: begin
               pix_rd_i = 1'b1;
               pop_mode = 0;
            end
         endcase
      end
   end

   initial begin
      logic [15:0] exp;
      forever begin
         @(negedge clk_i);
         if (!rst_i) begin
            if (frame_done_o) done_cnt++;
            if (pix_rd_i && !pix_valid_o) saw_invalid = 1'b1;
            if (pix_rd_i && pix_valid_o) begin
               exp = (out_q.size() != 0) ? out_q.pop_front() : 16'hdead;
               check_eq("pop_data", 32'(pix_data_o), 32'(exp));
            end
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int r0;
      rst_i       = 1'b1;
      start_i     = 1'b0;
      stop_i      = 1'b0;
      base_addr_i = '0;
      repeat (3) tick();
      check_reset_outputs("reset");
      rst_i = 1'b0;
      tick();
      check_reset_outputs("post_reset");

      // Frame streaming with wrap back to the base after FRAME_WORDS words.
      start_idle(32'h0000_1000);
      pop_mode   = 1;
      req_target = req_cnt + 20;
      wait_until("t1_reqs", 4, 3000);
      stop_and_drain("t1");
      check_eq("t1_frame_done", 32'(done_cnt), 32'(exp_done));

      // FIFO full holds off requests; address add wraps modulo 2^ADDR_W.
      start_idle(32'hFFFF_FFFE);
      r0 = req_cnt;
      repeat (80) tick();
      check_eq("t2_full_reqs", 32'(req_cnt - r0), 32'd4);
      check_eq("t2_full_stb", 32'(mem_stb_o), 32'd0);
      check_eq("t2_full_valid", 32'(pix_valid_o), 32'd1);
      pop_mode = 3;
      repeat (40) tick();
      check_eq("t2_one_more_req", 32'(req_cnt - r0), 32'd5);
      check_eq("t2_refull_stb", 32'(mem_stb_o), 32'd0);
      stop_and_drain("t2");

      // Consumer outruns a slow bridge: underflow sticks until start.
      start_idle(32'h0000_3000);
      lat_min     = 6;
      saw_invalid = 1'b0;
      pop_mode    = 2;
      repeat (80) tick();
      check_eq("t3_valid_dropped", 32'(saw_invalid), 32'd1);
      check_eq("t3_underflow", 32'(underflow_o), 32'd1);
      pop_mode = 0;
      stop_and_drain("t3");
      check_eq("t3_underflow_sticky", 32'(underflow_o), 32'd1);
      lat_min = 1;
      start_idle(32'h0000_5000);

      // Restart while a read is in flight: the returned word is dropped and the FIFO flushed.
      pop_mode = 1;
      wait_until("t4_wait_data", 2, 300);
      pop_mode    = 0;
      bridge_en   = 1'b0;
      discard     = 1'b1;
      base_addr_i = 32'h0000_2000;
      m_base      = 32'h0000_2000;
      m_idx       = 0;
      out_q.delete();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      wait_until("t4_new_req", 1, 100);
      check_eq("t4_fifo_empty", 32'(pix_valid_o), 32'd0);
      check_eq("t4_new_addr", mem_addr_o, 32'h0000_2000);
      bridge_en  = 1'b1;
      pop_mode   = 1;
      req_target = req_cnt + 6;
      wait_until("t4_reqs", 4, 1000);
      stop_and_drain("t4");

      // Stop during WAIT_ACC: that word still lands, then idle with data retained.
      start_idle(32'h0000_4000);
      r0 = req_cnt;
      wait_until("t5_stb", 1, 50);
      stop_i = 1'b1;
      tick();
      stop_i = 1'b0;
      wait_until("t5_idle", 0, 100);
      repeat (10) tick();
      check_eq("t5_one_req", 32'(req_cnt - r0), 32'd1);
      check_eq("t5_stb", 32'(mem_stb_o), 32'd0);
      check_eq("t5_active", 32'(active_o), 32'd0);
      check_eq("t5_retained", 32'(pix_valid_o), 32'd1);
      check_eq("t5_head", 32'(pix_data_o), 32'h0000_4000);
      pop_mode = 2;
      wait_until("t5_drain", 3, 20);
      pop_mode = 0;
      tick();
      check_eq("t5_words_left", 32'(out_q.size()), 32'd0);

      // Asynchronous reset during WAIT_DATA.
      start_idle(32'h0000_6000);
      pop_mode = 1;
      wait_until("t6_wait_data", 2, 300);
      pop_mode = 0;
      discard  = 1'b1;
      #2 rst_i = 1'b1;
      #1;
      check_reset_outputs("async_reset");
      out_q.delete();
      repeat (3) tick();
      rst_i = 1'b0;
      wait_until("t6_bridge_idle", 5, 100);
      repeat (10) tick();
      check_eq("t6_no_push", 32'(pix_valid_o), 32'd0);
      check_eq("t6_active", 32'(active_o), 32'd0);
      check_eq("t6_stb", 32'(mem_stb_o), 32'd0);
      check_eq("final_frame_done", 32'(done_cnt), 32'(exp_done));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule

// File: doc/sdram_frame_prefetch.md
Name: sdram_frame_prefetch

Overview:
- Wishbone-style read master that sits directly upstream of the SDRAM Wishbone bridge.
- Streams a linear frame region out of SDRAM, one word per bridge transaction, into an internal first-word-fall-through (FWFT) FIFO.
- A display or DMA consumer pops words from the FIFO at its own pace.
- Keeps the FIFO topped up and reports underflow so that starvation is visible.

Parameters:
FIFO_DEPTH, 16, FIFO entries; power of two, range 4..256
FRAME_WORDS, 76800, words per frame; address wraps after this many words
ADDR_W, 32, memory address width

Ports:
clk_i  input  1  system clock; the bridge runs on the same clock
rst_i  input  1  asynchronous active-high reset
start_i  input  1  1-cycle pulse: flush FIFO, (re)start frame at base_addr_i
stop_i  input  1  1-cycle pulse: stop issuing requests after the current transaction
base_addr_i  input  ADDR_W  frame base address, sampled on start_i and on each frame wrap
mem_stb_o  output  1  request strobe to bridge
mem_we_o  output  1  bridge op select; 1 = read, so it is tied to 1
mem_addr_o  output  ADDR_W  request address, stable while mem_stb_o or a transaction is active
mem_cyc_i  input  1  bridge busy/cycle; rise = request accepted, fall = transaction complete
mem_dat_i  input  16  read data from bridge, valid in the cycle mem_cyc_i is first seen low after being high
pix_rd_i  input  1  consumer pop
pix_data_o  output  16  FIFO head word (FWFT)
pix_valid_o  output  1  FIFO not empty
frame_done_o  output  1  1-cycle pulse when the last word of a frame is pushed
underflow_o  output  1  sticky: pop attempted while empty; cleared by start_i
active_o  output  1  prefetcher running

Behaviour:
- Reset: all outputs 0, mem_we_o = 1, FIFO empty, state IDLE, word counter 0.
- States:
  - IDLE: waits for start_i.
  - REQ: mem_stb_o = 1 at the current address.
  - WAIT_ACC: holds mem_stb_o = 1 until mem_cyc_i = 1.
  - WAIT_DATA: mem_stb_o = 0; waits until mem_cyc_i = 0.
  - PUSH: writes the captured word into the FIFO and advances the address.
- Transitions:
  - IDLE -> REQ on start_i.
  - REQ -> WAIT_ACC in the same cycle the strobe is raised. mem_stb_o is registered; it rises the cycle after REQ is entered.
  - WAIT_ACC -> WAIT_DATA on mem_cyc_i = 1; mem_stb_o drops in the next cycle.
  - WAIT_DATA -> PUSH on the first cycle mem_cyc_i = 0. mem_dat_i is captured in that cycle.
  - PUSH -> REQ if the FIFO, after the push, has at least 1 free entry and no stop/start is pending.
  - PUSH -> IDLE if stop is pending.
  - Otherwise PUSH -> a hold in REQ with mem_stb_o = 0 until a free entry exists.
- Issue rules:
  - At most one outstanding transaction at a time.
  - A request is raised only if FIFO count < FIFO_DEPTH, which guarantees space for the returned word.
  - The FIFO never overflows.
- Address generation:
  - word_cnt runs 0..FRAME_WORDS-1; mem_addr_o = base + word_cnt.
  - The add is ADDR_W-bit modulo, with no carry out.
  - When word_cnt = FRAME_WORDS-1 is pushed: frame_done_o pulses, word_cnt returns to 0, and base_addr_i is re-sampled.
- start_i while idle: FIFO flushed, underflow_o cleared, word_cnt = 0, base latched. Next cycle goes to REQ.
- start_i mid-transaction: the bridge transaction cannot be aborted, so a restart is marked pending.
  - The in-flight word is discarded when returned; it is not pushed.
  - Then flush, re-latch base, and go to REQ.
  - start_i in IDLE or REQ takes effect immediately.
- stop_i: a pending stop lets the in-flight word push normally, then the block goes to IDLE.
  - The FIFO retains its contents for draining.
  - stop_i and start_i in the same cycle: start_i wins.
- FIFO:
  - Registered count, 0..FIFO_DEPTH; pointers are log2(FIFO_DEPTH) bits and wrap naturally.
  - Pop when pix_rd_i && pix_valid_o.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Push into an empty FIFO: pix_valid_o = 1 and pix_data_o = the word in the next cycle.
  - pix_rd_i while empty: no pointer change; underflow_o is set the next cycle.
- active_o = 1 in every state except IDLE.

Test Plan:
1. Reset, then start_i with base 0x1000 and FRAME_WORDS = 8; a bridge model returns data = addr[15:0] with 3 cycles of latency -> requests at 0x1000..0x1007, FIFO holds 0x1000..0x1007, frame_done_o pulses once on the 8th push, and requests then resume at 0x1000.
2. No pops, FIFO_DEPTH = 4 -> exactly 4 transactions; mem_stb_o stays 0 while count = 4. Pop one -> exactly one new request for the next address.
3. Continuous pops every cycle with slow bridge latency -> pix_valid_o drops, underflow_o sets and stays 1; start_i clears it.
4. start_i with base 0x2000 asserted during WAIT_DATA -> the returned word is discarded, the FIFO is empty afterwards, and the next request address is 0x2000.
5. stop_i during WAIT_ACC -> that word is pushed, then the state is IDLE, mem_stb_o = 0, the FIFO drains normally, and active_o = 0.
6. rst_i asserted asynchronously mid-WAIT_DATA -> all outputs return to their reset values immediately, with no push after reset release.
